// File: rtl/key_conditioner.sv
// key_conditioner
// ---------------
// Per-key input stage for the clock front panel. Each raw active-low button
// is synchronised (2 flops), debounced by a small per-key IDLE/HELD FSM with
// its own counter, and turned into a clean level plus one-clk press/release
// pulses for the mode FSM and the time-set logic.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   key_n        in   [NUM_KEYS]  raw buttons, asynchronous, 0 = pressed
//   key_level    out  [NUM_KEYS]  debounced state, 1 = pressed
//   key_press    out  [NUM_KEYS]  one-clk pulse per accepted press (and per
//                                 auto-repeat step when enabled)
//   key_release  out  [NUM_KEYS]  one-clk pulse per accepted release
//
// Build option:
//   KEYCOND_AUTOREPEAT_EN  when defined, a held key emits extra key_press
//                          pulses: the first REPEAT_DELAY_CYCLES after entering
//                          HELD, then every REPEAT_PERIOD_CYCLES.
//
// Timing: a clean edge on key_n appears on the outputs 2+DEBOUNCE_CYCLES edges
// after the first edge that samples it (2 sync flops, DEBOUNCE_CYCLES-1 counting
// edges, the FSM transition edge, and the registered output edge).

module key_conditioner #(
  parameter int NUM_KEYS             = 4,
  parameter int DEBOUNCE_CYCLES      = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES  = 25_000_000,
  parameter int REPEAT_PERIOD_CYCLES = 5_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ?
                          DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
  localparam int MAX_P  = (MAX_AB > REPEAT_PERIOD_CYCLES) ? MAX_AB : REPEAT_PERIOD_CYCLES;
  localparam int CNT_W  = $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_e;

  // Synchroniser holds raw key_n polarity, so reset value 1 means released.
  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;

  state_e              state_q [NUM_KEYS];
  state_e              state_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];

  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;

  logic [NUM_KEYS-1:0] rep_fire;

`ifdef KEYCOND_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY  = CNT_W'(REPEAT_DELAY_CYCLES);
  localparam logic [CNT_W-1:0] REP_PERIOD = CNT_W'(REPEAT_PERIOD_CYCLES);

  logic [CNT_W-1:0]    rep_cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    rep_cnt_d [NUM_KEYS];
  // 0 while waiting for the first repeat, 1 once in the periodic phase.
  logic [NUM_KEYS-1:0] rep_phase_q, rep_phase_d;

  // rep_cnt counts cycles spent in HELD (0 in the first HELD cycle). After a
  // fire it restarts at 1 so the next match is exactly one period later.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      rep_cnt_d[k]   = rep_cnt_q[k];
      rep_phase_d[k] = rep_phase_q[k];
      rep_fire[k]    = 1'b0;
      if (state_q[k] != ST_HELD) begin
        rep_cnt_d[k]   = '0;
        rep_phase_d[k] = 1'b0;
      end else if (rep_cnt_q[k] == (rep_phase_q[k] ? REP_PERIOD : REP_DELAY)) begin
        rep_fire[k]    = 1'b1;
        rep_cnt_d[k]   = CNT_W'(1);
        rep_phase_d[k] = 1'b1;
      end else if (rep_cnt_q[k] != CNT_MAX) begin
        rep_cnt_d[k] = rep_cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_KEYS; k++) rep_cnt_q[k] <= '0;
      rep_phase_q <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) rep_cnt_q[k] <= rep_cnt_d[k];
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  assign rep_fire = '0;
`endif

  // Channel FSMs plus output decode. Outputs are derived from the FSM state
  // one edge later: level follows state, and a press/release pulse is the
  // single cycle where state and the registered level disagree.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      state_d[k]   = state_q[k];
      cnt_d[k]     = cnt_q[k];
      level_d[k]   = 1'b0;
      press_d[k]   = 1'b0;
      release_d[k] = 1'b0;

      case (state_q[k])
        ST_IDLE: begin
          if (!sync2_q[k]) begin
            if (cnt_q[k] == DEB_LAST) begin
              state_d[k] = ST_HELD;
              cnt_d[k]   = '0;
            end else if (cnt_q[k] != CNT_MAX) begin
              cnt_d[k] = cnt_q[k] + 1'b1;
            end
          end else begin
            cnt_d[k] = '0;
          end
        end
        ST_HELD: begin
          if (sync2_q[k]) begin
            if (cnt_q[k] == DEB_LAST) begin
              state_d[k] = ST_IDLE;
              cnt_d[k]   = '0;
            end else if (cnt_q[k] != CNT_MAX) begin
              cnt_d[k] = cnt_q[k] + 1'b1;
            end
          end else begin
            cnt_d[k] = '0;
          end
        end
        default: begin
          state_d[k] = ST_IDLE;
          cnt_d[k]   = '0;
        end
      endcase

      level_d[k]   = (state_q[k] == ST_HELD);
      press_d[k]   = ((state_q[k] == ST_HELD) && !level_q[k]) || rep_fire[k];
      release_d[k] = (state_q[k] == ST_IDLE) && level_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20,
// REPEAT_PERIOD_CYCLES=8. Each step drives rst/key_n before a rising edge and
// compares all three outputs half a clock after that edge. A key_n change
// first sampled by edge E0 must show up on the outputs after edge E6.

module tb_key_conditioner;

  localparam int NK   = 4;
  localparam int DEB  = 4;
  localparam int RDLY = 20;
  localparam int RPER = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .NUM_KEYS             (NK),
    .DEBOUNCE_CYCLES      (DEB),
    .REPEAT_DELAY_CYCLES  (RDLY),
    .REPEAT_PERIOD_CYCLES (RPER)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
  );

  typedef struct {
    logic          rst;
    logic [NK-1:0] key_n;
    logic [NK-1:0] lvl;
    logic [NK-1:0] prs;
    logic [NK-1:0] rel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [NK-1:0] kn,
                     input logic [NK-1:0] lv, input logic [NK-1:0] pr,
                     input logic [NK-1:0] rl);
    vec_t v;
    v.rst = r; v.key_n = kn; v.lvl = lv; v.prs = pr; v.rel = rl;
    vecs.push_back(v);
  endtask

  // One clock: drive, wait for the edge, compare half a cycle later.
  task automatic cyc(input logic r, input logic [NK-1:0] kn,
                     input logic [NK-1:0] lv, input logic [NK-1:0] pr,
                     input logic [NK-1:0] rl, input string nm);
    rst   = r;
    key_n = kn;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (key_level !== lv || key_press !== pr || key_release !== rl) begin
      n_err++;
      $display("FAIL %s step %0d: got level=%b press=%b release=%b, want level=%b press=%b release=%b",
               nm, n_vec, key_level, key_press, key_release, lv, pr, rl);
    end
  endtask

  // Expected key_press[2] for step r of the held-key sequence (key accepted at r=6).
  function automatic logic rep_expected(input int r);
    logic e;
    e = (r == 6);
`ifdef KEYCOND_AUTOREPEAT_EN
    if (r >= 6 + RDLY && ((r - 6 - RDLY) % RPER) == 0) e = 1'b1;
`endif
    return e;
  endfunction

  initial begin
    rst   = 1'b1;
    key_n = 4'b1111;

    // ---- table: reset, idle, clean press/release on key 0, simultaneous 3:2
    for (int i = 0; i < 3; i++)  add(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 50; i++) add(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++)  add(1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b1110, 4'b0001, 4'b0001, 4'b0000);
    for (int i = 0; i < 5; i++)  add(1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++)  add(1'b0, 4'b1111, 4'b0001, 4'b0000, 4'b0000);
    add(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0001);
    for (int i = 0; i < 3; i++)  add(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++)  add(1'b0, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0011, 4'b1100, 4'b1100, 4'b0000);
    for (int i = 0; i < 3; i++)  add(1'b0, 4'b0011, 4'b1100, 4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++)  add(1'b0, 4'b1111, 4'b1100, 4'b0000, 4'b0000);
    add(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1100);
    for (int i = 0; i < 3; i++)  add(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);

    for (int i = 0; i < vecs.size(); i++)
      cyc(vecs[i].rst, vecs[i].key_n, vecs[i].lvl, vecs[i].prs, vecs[i].rel, "table");

    // ---- bounce on key 1: 3 low, 1 high, 3 low, then high -> nothing
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b0000, "bounce_reject");
    cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "bounce_reject");
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b0000, "bounce_reject");
    for (int i = 0; i < 8; i++) cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "bounce_reject");

    // ---- same bounce then steady low -> exactly one press, 6 after the last fall
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b0000, "bounce_accept");
    cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "bounce_accept");
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b0000, "bounce_accept");
    cyc(1'b0, 4'b1101, 4'b0010, 4'b0010, 4'b0000, "bounce_accept");
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'b1101, 4'b0010, 4'b0000, 4'b0000, "bounce_hold");
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'b1111, 4'b0010, 4'b0000, 4'b0000, "bounce_rel");
    cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, "bounce_rel");
    cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "bounce_rel");

    // ---- reset while key 0 is held: clear, no release, fresh press 6 after rst
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b0000, "rst_mid_pre");
    cyc(1'b0, 4'b1110, 4'b0001, 4'b0001, 4'b0000, "rst_mid_pre");
    cyc(1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0000, "rst_mid_pre");
    cyc(1'b1, 4'b1110, 4'b0000, 4'b0000, 4'b0000, "rst_mid_clear");
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b0000, "rst_mid_norel");
    cyc(1'b0, 4'b1110, 4'b0001, 4'b0001, 4'b0000, "rst_mid_repress");
    cyc(1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0000, "rst_mid_repress");
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'b1111, 4'b0001, 4'b0000, 4'b0000, "rst_mid_rel");
    cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, "rst_mid_rel");
    cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "rst_mid_rel");

    // ---- long hold on key 2: single press, or repeats at +20, +28, ... if enabled
    for (int r = 0; r < 62; r++)
      cyc(1'b0, 4'b1011, (r >= 6) ? 4'b0100 : 4'b0000,
          rep_expected(r) ? 4'b0100 : 4'b0000, 4'b0000, "long_hold");
    for (int r = 62; r < 68; r++)
      cyc(1'b0, 4'b1111, 4'b0100, rep_expected(r) ? 4'b0100 : 4'b0000, 4'b0000, "long_hold_rel");
    cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, "long_hold_rel");
    cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "long_hold_rel");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
